// File: rtl/axis_fifo_ctrl.sv
// axis_fifo_ctrl: AXI-Stream FIFO of arbitrary depth with occupancy, almost-full
// and TLAST-beat count reporting. Output is first-word fall-through: the head
// entry is read combinationally from registered storage.
//
// Optional feature macro: AXIS_FIFO_PACKET_MODE_EN. When it is defined, the FIFO
// works store-and-forward: a packet is only offered downstream once its TLAST
// beat is stored. A packet larger than the FIFO is cut through instead.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_t*_i / s_tready_o slave stream (data, strb, keep, last, id, dest, user, valid)
//   m_t*_o / m_tready_i master stream, same fields
//   level_o             entries stored
//   almost_full_o       level_o >= AF_THRESH
//   pkt_count_o         stored beats carrying TLAST
module axis_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  localparam int KW = DATA_WIDTH / 8,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KW-1:0]         s_tstrb_i,
  input  logic [KW-1:0]         s_tkeep_i,
  input  logic                  s_tlast_i,
  input  logic [ID_WIDTH-1:0]   s_tid_i,
  input  logic [DEST_WIDTH-1:0] s_tdest_i,
  input  logic [USER_WIDTH-1:0] s_tuser_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic [KW-1:0]         m_tstrb_o,
  output logic [KW-1:0]         m_tkeep_o,
  output logic                  m_tlast_o,
  output logic [ID_WIDTH-1:0]   m_tid_o,
  output logic [DEST_WIDTH-1:0] m_tdest_o,
  output logic [USER_WIDTH-1:0] m_tuser_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [LW-1:0]         level_o,
  output logic                  almost_full_o,
  output logic [LW-1:0]         pkt_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFT   = LW'(AF_THRESH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
    logic [KW-1:0]         keep;
    logic [KW-1:0]         strb;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          wr_ent, rd_ent;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d, pkt_q, pkt_d;
  logic          push, pop, push_l, pop_l, out_ok;

  assign wr_ent = '{last: s_tlast_i, user: s_tuser_i, dest: s_tdest_i, id: s_tid_i,
                    keep: s_tkeep_i, strb: s_tstrb_i, data: s_tdata_i};
  assign rd_ent = mem_q[rp_q];

  // A pop while full does not open the input in the same cycle: ready is
  // derived from registered level only.
  assign s_tready_o = !rst && (level_q != FULL);
  assign push       = s_tvalid_i && s_tready_o;
  assign pop        = m_tvalid_o && m_tready_i;
  assign push_l     = push && s_tlast_i;
  assign pop_l      = pop && rd_ent.last;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    pkt_d   = pkt_q;
    // Explicit wrap so any DEPTH works, not just powers of two.
    if (push) wp_d = (wp_q == PLAST) ? '0 : wp_q + 1'b1;
    if (pop)  rp_d = (rp_q == PLAST) ? '0 : rp_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: ;
    endcase
    case ({push_l, pop_l})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      pkt_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      pkt_q   <= pkt_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_ent;
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic rel_q, rel_d, full_nolast;

  // Full with no complete packet inside can never gain a TLAST on its own:
  // cut through until the oversize packet's last beat leaves.
  assign full_nolast = (level_q == FULL) && (pkt_q == '0);

  always_comb begin
    rel_d = rel_q;
    if (pop_l)            rel_d = 1'b0;
    else if (full_nolast) rel_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rel_q <= 1'b0;
    else     rel_q <= rel_d;
  end

  // full_nolast is ORed in so the head is offered in the same cycle the
  // release condition appears rather than one cycle later.
  assign out_ok = (pkt_q != '0) || rel_q || full_nolast;
`else
  assign out_ok = 1'b1;
`endif

  assign m_tvalid_o    = !rst && (level_q != '0) && out_ok;
  assign m_tdata_o     = rd_ent.data;
  assign m_tstrb_o     = rd_ent.strb;
  assign m_tkeep_o     = rd_ent.keep;
  assign m_tlast_o     = rd_ent.last;
  assign m_tid_o       = rd_ent.id;
  assign m_tdest_o     = rd_ent.dest;
  assign m_tuser_o     = rd_ent.user;

  assign level_o       = rst ? '0 : level_q;
  assign pkt_count_o   = rst ? '0 : pkt_q;
  assign almost_full_o = !rst && (level_q >= AFT);

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl at DEPTH=5, AF_THRESH=4. A queue-based reference
// model predicts every output each cycle; directed phases plus a random soak.
module tb_axis_fifo_ctrl;
  localparam int DW = 32, KW = 4, IW = 4, DEPTH = 5, AF = 4, LW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [IW-1:0] dest;
    logic [IW-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tstrb, s_tkeep, m_tstrb, m_tkeep;
  logic          s_tlast, m_tlast, s_tvalid, m_tvalid, s_tready, m_tready;
  logic [IW-1:0] s_tid, s_tdest, s_tuser, m_tid, m_tdest, m_tuser;
  logic [LW-1:0] level, pkt_count;
  logic          almost_full;

  always #5 clk = ~clk;

  axis_fifo_ctrl #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(IW), .USER_WIDTH(IW),
                   .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst),
    .s_tdata_i(s_tdata), .s_tstrb_i(s_tstrb), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast),
    .s_tid_i(s_tid), .s_tdest_i(s_tdest), .s_tuser_i(s_tuser),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tstrb_o(m_tstrb), .m_tkeep_o(m_tkeep), .m_tlast_o(m_tlast),
    .m_tid_o(m_tid), .m_tdest_o(m_tdest), .m_tuser_o(m_tuser),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .level_o(level), .almost_full_o(almost_full), .pkt_count_o(pkt_count)
  );

  beat_t q[$];
  bit    rel_m, cur_v, acc;
  beat_t cur;
  int    n_chk, n_bad, lastpct;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_last();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = $urandom; b.strb = 4'($urandom); b.keep = 4'($urandom);
    b.id = 4'($urandom); b.dest = 4'($urandom); b.user = 4'($urandom);
    b.last = ($urandom_range(99) < lastpct);
    return b;
  endfunction

  // Drive one cycle (called just after a negedge), check outputs against the
  // model, then advance the model across the posedge.
  task automatic step(input bit r, input bit sv, input beat_t b, input bit mr);
    bit ev, er, pl, fnl;
    int sz;
    rst = r; s_tvalid = sv; m_tready = mr;
    s_tdata = b.data; s_tstrb = b.strb; s_tkeep = b.keep; s_tlast = b.last;
    s_tid = b.id; s_tdest = b.dest; s_tuser = b.user;
    #1;
    sz = q.size();
    er = !r && sz != DEPTH;
    ev = !r && sz != 0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    ev = ev && (n_last() != 0 || rel_m || sz == DEPTH);
`endif
    chk("tready", s_tready, er);
    chk("tvalid", m_tvalid, ev);
    chk("level", level, r ? 0 : sz);
    chk("afull", almost_full, !r && sz >= AF);
    chk("pkt", pkt_count, r ? 0 : n_last());
    if (ev) begin
      chk("tdata", m_tdata, q[0].data);
      chk("side", {m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser},
          {q[0].strb, q[0].keep, q[0].last, q[0].id, q[0].dest, q[0].user});
    end
    fnl = (sz == DEPTH) && (n_last() == 0);
    pl = 0;
    @(posedge clk);
    acc = 0;
    if (r) begin
      q.delete();
      rel_m = 0;
    end else begin
      if (ev && mr) begin pl = q[0].last; void'(q.pop_front()); end
      if (sv && er) begin q.push_back(b); acc = 1; end
      if (pl) rel_m = 0;
      else if (fnl) rel_m = 1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      if (!cur_v && $urandom_range(99) < pv) begin cur = rand_beat(); cur_v = 1; end
      step(0, cur_v, cur, $urandom_range(99) < pr);
      if (acc) cur_v = 0;
    end
  endtask

  task automatic send(input beat_t b, input bit mr);
    int k = 0;
    acc = 0;
    while (!acc && k < 20) begin step(0, 1, b, mr); k++; end
    chk("send_acc", acc, 1);
  endtask

  task automatic drain();
    if (!cur_v) begin cur = rand_beat(); cur_v = 1; end
    cur.last = 1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      step(0, cur_v, cur, 1);
      if (acc) cur_v = 0;
    end
    chk("drain_lvl", level, 0);
  endtask

  initial begin
    beat_t b;
    rst = 1; s_tvalid = 0; m_tready = 0; cur_v = 0; rel_m = 0;
    n_chk = 0; n_bad = 0; lastpct = 25;
    s_tdata = '0; s_tstrb = '0; s_tkeep = '0; s_tlast = 0;
    s_tid = '0; s_tdest = '0; s_tuser = '0;
    @(negedge clk);
    step(1, 0, '0, 0);
    step(1, 1, rand_beat(), 1);   // push attempt while in reset must be refused

    // Three beats held, then drained in order.
    b = '0; b.data = 32'h11; step(0, 1, b, 0);
    b.data = 32'h22;         step(0, 1, b, 0);
    b.data = 32'h33; b.last = 1; step(0, 1, b, 0);
    chk("t1_level", level, 3);
    chk("t1_pkt", pkt_count, 1);
    chk("t1_head", m_tdata, 32'h11);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
    chk("t1_empty", level, 0);

    // Fill to full; sixth beat waits; one pop reopens input a cycle later.
    run(7, 100, 0);
    chk("full_lvl", level, 5);
    chk("full_rdy", s_tready, 0);
    chk("full_af", almost_full, 1);
    run(1, 100, 100);
    chk("reopen_rdy", s_tready, 1);
    drain();

    // Steady state at level 2 with one beat in and one out per cycle.
    lastpct = 100;
    run(2, 100, 0);
    for (int i = 0; i < 20; i++) begin
      run(1, 100, 100);
      chk("steady_lvl", level, 2);
    end
    drain();

    // 4-beat packet with sink ready: held until TLAST stored (packet mode).
    for (int i = 0; i < 4; i++) begin b = rand_beat(); b.last = (i == 3); send(b, 1); end
    drain();

    // 7-beat packet through a 5-entry FIFO: must cut through when full.
    for (int i = 0; i < 7; i++) begin b = rand_beat(); b.last = (i == 6); send(b, i >= 5); end
    drain();

    // Reset in the middle of a packet, then a 1-beat packet.
    lastpct = 0;
    for (int i = 0; i < 3; i++) begin b = rand_beat(); send(b, 0); end
    step(1, 0, '0, 0);
    cur_v = 0;
    rst = 0; #1;
    chk("rst_lvl", level, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_ready", s_tready, 1);
    b = rand_beat(); b.last = 1; send(b, 1);
    step(0, 0, '0, 1);
    chk("post_rst_lvl", level, 0);

    // Random soak with mixed packet lengths and backpressure.
    lastpct = 25;
    run(300, 60, 60);
    run(100, 90, 30);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_fifo_ctrl.md
# axis_fifo_ctrl

Parametrised AXI-Stream FIFO for the router datapath: arbitrary (non-power-of-two) depth, occupancy reporting, an almost-full flag for upstream flow control, and an optional store-and-forward packet mode. Sits between each router input port and the switch stage. It replaces the fixed 4-entry queue wherever occupancy or packet-atomic forwarding is needed.

## Interface
Parameters:
- DATA_WIDTH, 32, TDATA width; TSTRB/TKEEP are DATA_WIDTH/8.
- ID_WIDTH, 4, TID width.
- DEST_WIDTH, 4, TDEST width.
- USER_WIDTH, 4, TUSER width.
- DEPTH, 8, entry count; any integer >= 2.
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in  axis_if.s  —  slave stream: TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER, TVALID, TREADY.
- out  axis_if.m  —  master stream, same fields.
- level  out  $clog2(DEPTH+1)  entries currently stored.
- almost_full  out  1  level >= AF_THRESH.
- pkt_count  out  $clog2(DEPTH+1)  stored beats with TLAST=1 (always present; used by packet mode).

## Operation
- Storage: DEPTH-entry array of all stream fields except TVALID/TREADY; write pointer wp, read pointer rp, each 0..DEPTH-1.
- Pointer wrap: explicit compare; pointer at DEPTH-1 advances to 0. No modulo-by-power-of-two.
- Push = in.TVALID && in.TREADY: write array[wp], advance wp.
- Pop = out.TVALID && out.TREADY: advance rp.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Saturates by construction at 0..DEPTH.
- pkt_count: +1 on push with in.TLAST=1, -1 on pop of a beat with TLAST=1, unchanged if both in the same cycle.
- in.TREADY = !rst && (level != DEPTH). A pop in a full cycle does not enable a push in that same cycle.
- Output is first-word fall-through: out fields = array[rp] (registered memory, combinational read). Fields are don't-care while out.TVALID=0.
- Normal mode: out.TVALID = !rst && (level != 0).
- Beat order, and all sideband fields per beat, are preserved exactly.

## Timing
- Reset (rst=1 sampled at an edge): wp=rp=0, level=0, pkt_count=0, release flag cleared; contents discarded. While rst=1: in.TREADY=0, out.TVALID=0, almost_full=0, level=0, pkt_count=0.
- Reset mid-packet: partial packet is dropped. The first beat after reset starts a new packet.
- Latency: a beat pushed at edge N is visible on out (TVALID=1) in the cycle after edge N, provided it is at the head. No same-cycle pass-through when empty.
- Throughput: one beat per cycle sustained when 0 < level < DEPTH with simultaneous push and pop.
- Full: level==DEPTH gives in.TREADY=0 the following cycle onward, until a pop edge.
- Empty: level==0 gives out.TVALID=0. A simultaneous push and pop cannot occur at empty.
- level, almost_full and pkt_count are registered-state outputs, updated one cycle after the causing edge.
- out.TVALID, once high, stays high until a pop in normal mode (AXIS rule). Packet mode guarantees the same.

## Configuration
- AXIS_FIFO_PACKET_MODE_EN defined, store-and-forward mode: out.TVALID = !rst && level!=0 && (pkt_count!=0 || release).
  - release is a flag set when level==DEPTH && pkt_count==0 (oversize packet). It is cleared on the pop of a TLAST beat.
  - While release is set, the FIFO cut-throughs until the packet's end, which prevents deadlock.
  - Once a pop begins a packet, out.TVALID stays high until its TLAST beat pops, since pkt_count or release holds.
- AXIS_FIFO_PACKET_MODE_EN undefined: normal cut-through mode as above. pkt_count is still maintained; the release logic is absent.

## Test plan
- Reset, then push 3 beats (TDATA 0x11, 0x22, 0x33; TLAST on 0x33) with out.TREADY=0 -> level=3, pkt_count=1, out.TDATA=0x11; after enabling out.TREADY, beats emerge in order, then level=0.
- DEPTH=5, AF_THRESH=4: push 5 beats with no pop -> almost_full=1 at level 4, in.TREADY=0 at level 5; the 6th beat is held; pop one -> next cycle in.TREADY=1. Pointers wrap 4->0 correctly over 12 beats.
- Continuous push and pop at level 2 for 20 cycles -> level stays 2 and one beat per cycle goes out with no gaps.
- Packet mode, DEPTH=8: push a 4-beat packet with out.TREADY=1 -> out.TVALID=0 until the TLAST beat is stored, then 4 consecutive beats are output.
- Packet mode, DEPTH=4: push a 6-beat packet -> at level 4, release=1 and out.TVALID=1; all 6 beats pass; release clears after the TLAST pop.
- Assert rst for 1 cycle mid-packet at level 3 -> next cycle level=0, out.TVALID=0, in.TREADY=1; a following 1-beat packet passes intact.
